// File: rtl/hwag_math_pkg.sv
// -----------------------------------------------------------------------------
// hwag_math_pkg
// Shared definitions for the HWAG divider arbiter:
//   - div_state_t       : sequencer states (IDLE, LOAD, RUN, DONE)
//   - DEFAULT_WIDTH     : default operand/result width
//   - DIV_ZERO_QUOTIENT : all-ones quotient reported for a zero divisor.
//                         It is wide enough for any WIDTH up to MAX_WIDTH.
//                         Users take the low WIDTH bits.
// -----------------------------------------------------------------------------
package hwag_math_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int MAX_WIDTH     = 64;

    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/hwag_rr_picker.sv
// -----------------------------------------------------------------------------
// hwag_rr_picker
// Combinational round-robin selector. The winner is the first set req bit
// found by scanning upward from last+1, wrapping modulo REQ_N.
// Ports:
//   req         in  REQ_N  : request levels
//   last        in  IDX_W  : index of the previously served requester
//   grant_valid out 1      : at least one request is pending
//   grant_idx   out IDX_W  : winning requester (0 when grant_valid is low)
// -----------------------------------------------------------------------------
module hwag_rr_picker
    import hwag_math_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // cand[k] is the requester checked at scan position k (k = 0 is last+1).
    logic [IDX_W-1:0] cand [REQ_N];
    logic [REQ_N-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_N; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((32'(last) + gi + 1) % REQ_N);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from the far end downward so that the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/hwag_div_arbiter.sv
// -----------------------------------------------------------------------------
// hwag_div_arbiter
// Shares one iterative divider among REQ_N HWAG requesters. The block performs
// round-robin arbitration and latches the winner's operands. It then sequences
// the divider (LOAD with start low, RUN with start high until rdy). Results are
// returned with a one-cycle one-hot ack.
//
// Optional feature (macro HWAG_DIV_ARB_TIMEOUT_EN):
//   defined   -> a RUN watchdog aborts after TIMEOUT cycles without div_rdy.
//                The abort completes with err=1 and quotient=remainder=0.
//   undefined -> no watchdog. err is tied 0, and RUN waits for div_rdy.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   req[REQ_N]                : request levels (held until ack)
//   dividend_in, divider_in   : packed operands; requester i uses
//                               bits [i*WIDTH +: WIDTH]
//   ack[REQ_N]                : one-hot result-valid pulse
//   quotient, remainder       : registered results, held between acks
//   dz, err                   : divide-by-zero / watchdog-abort flags
//   busy                      : high outside IDLE
//   grant_id                  : current or last granted requester
//   div_start, div_dividend,
//   div_divider               : to the shared divider
//   div_result, div_remainder,
//   div_rdy                   : from the shared divider
// -----------------------------------------------------------------------------
module hwag_div_arbiter
    import hwag_math_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int REQ_N   = 4,
    parameter int TIMEOUT = 2 * WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_N-1:0]           req,
    input  logic [REQ_N*WIDTH-1:0]     dividend_in,
    input  logic [REQ_N*WIDTH-1:0]     divider_in,
    output logic [REQ_N-1:0]           ack,
    output logic [WIDTH-1:0]           quotient,
    output logic [WIDTH-1:0]           remainder,
    output logic                       dz,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(REQ_N)-1:0]   grant_id,
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divider,
    input  logic [WIDTH-1:0]           div_result,
    input  logic [WIDTH-1:0]           div_remainder,
    input  logic                       div_rdy
);

    localparam int IDX_W = $clog2(REQ_N);

    div_state_t       state_reg;
    logic [IDX_W-1:0] last_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] divider_reg;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    // Unpack the requester operand buses so the winner can be indexed directly.
    logic [WIDTH-1:0] dividend_arr [REQ_N];
    logic [WIDTH-1:0] divider_arr  [REQ_N];

    genvar gi;
    generate
        for (gi = 0; gi < REQ_N; gi++) begin : g_unpack
            assign dividend_arr[gi] = dividend_in[gi*WIDTH +: WIDTH];
            assign divider_arr[gi]  = divider_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    hwag_rr_picker #(
        .REQ_N (REQ_N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req         (req),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // The divider always sees the latched operands. Requester buses are free
    // to change once the grant has been taken.
    assign div_dividend = dividend_reg;
    assign div_divider  = divider_reg;

`ifdef HWAG_DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] run_cnt_reg;
    logic             err_reg;
    assign err = err_reg;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            last_reg     <= IDX_W'(REQ_N - 1);
            grant_id     <= '0;
            dividend_reg <= '0;
            divider_reg  <= '0;
            ack          <= '0;
            quotient     <= '0;
            remainder    <= '0;
            dz           <= 1'b0;
            busy         <= 1'b0;
            div_start    <= 1'b0;
`ifdef HWAG_DIV_ARB_TIMEOUT_EN
            err_reg      <= 1'b0;
            run_cnt_reg  <= '0;
`endif
        end else begin
            // ack is a single-cycle pulse. It is only set on the edge into DONE.
            ack <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_reg    <= ST_LOAD;
                        grant_id     <= grant_idx;
                        dividend_reg <= dividend_arr[grant_idx];
                        divider_reg  <= divider_arr[grant_idx];
                        busy         <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (divider_reg == '0) begin
                        // A zero divisor skips the datapath entirely.
                        state_reg <= ST_DONE;
                        quotient  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        remainder <= dividend_reg;
                        dz        <= 1'b1;
`ifdef HWAG_DIV_ARB_TIMEOUT_EN
                        err_reg   <= 1'b0;
`endif
                        ack       <= REQ_N'(1) << grant_id;
                    end else begin
                        state_reg <= ST_RUN;
                        div_start <= 1'b1;
`ifdef HWAG_DIV_ARB_TIMEOUT_EN
                        run_cnt_reg <= '0;
`endif
                    end
                end

                ST_RUN: begin
                    if (div_rdy) begin
                        state_reg <= ST_DONE;
                        div_start <= 1'b0;
                        quotient  <= div_result;
                        remainder <= div_remainder;
                        dz        <= 1'b0;
`ifdef HWAG_DIV_ARB_TIMEOUT_EN
                        err_reg   <= 1'b0;
`endif
                        ack       <= REQ_N'(1) << grant_id;
                    end
`ifdef HWAG_DIV_ARB_TIMEOUT_EN
                    // The counter is 0 in the first RUN cycle. It therefore
                    // equals TIMEOUT-1 in the TIMEOUT-th RUN cycle.
                    else if (run_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg <= ST_DONE;
                        div_start <= 1'b0;
                        quotient  <= '0;
                        remainder <= '0;
                        dz        <= 1'b0;
                        err_reg   <= 1'b1;
                        ack       <= REQ_N'(1) << grant_id;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    last_reg  <= grant_id;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
